// File: rtl/pacman_mover_if.sv
// Player-control and map-lookup signals of the Pac-Man movement controller.
// The mover takes the master side; the game/map environment takes the slave side.
interface pacman_mover_if;
  logic       tick;
  logic       dir_valid;
  logic [1:0] dir_req;
  logic [7:0] map_x;
  logic [6:0] map_y;
  logic       map_q;
  logic [7:0] pac_x;
  logic [6:0] pac_y;
  logic [1:0] pac_dir;
  logic       moving;
  logic       step_done;

  modport master (
    input  tick, dir_valid, dir_req, map_q,
    output map_x, map_y, pac_x, pac_y, pac_dir, moving, step_done
  );

  modport slave (
    output tick, dir_valid, dir_req, map_q,
    input  map_x, map_y, pac_x, pac_y, pac_dir, moving, step_done
  );
endinterface

// File: rtl/pacman_mover.sv
// Tile-granular Pac-Man mover: on each tick it probes the requested direction,
// falls back to the current one, and commits a single-tile step (with tunnel wrap).
module pacman_mover #(
  parameter int START_X = 13,
  parameter int START_Y = 18,
  parameter int MAX_X   = 26,
  parameter int MAX_Y   = 23
) (
  input  logic           clk,
  input  logic           reset,
  pacman_mover_if.master bus
);
  typedef enum logic [1:0] {IDLE, CHK_REQ, CHK_CUR} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  state_t     state_reg;
  logic [7:0] pac_x_reg;
  logic [6:0] pac_y_reg;
  logic [1:0] cur_dir_reg;
  logic [1:0] req_dir_reg;
  logic       moving_reg;
  logic       step_done_reg;

  logic [1:0] probe_dir;
  logic [7:0] nbr_x;
  logic [6:0] nbr_y;

  // Neighbour of the current tile in the direction being probed this state.
  always_comb begin
    probe_dir = (state_reg == CHK_CUR) ? cur_dir_reg : req_dir_reg;
    nbr_x     = pac_x_reg;
    nbr_y     = pac_y_reg;
    case (probe_dir)
      DIR_UP:    nbr_y = (pac_y_reg == 7'd0) ? 7'(MAX_Y) : pac_y_reg - 7'd1;
      DIR_RIGHT: nbr_x = (pac_x_reg == 8'(MAX_X)) ? 8'd0 : pac_x_reg + 8'd1;
      DIR_DOWN:  nbr_y = (pac_y_reg == 7'(MAX_Y)) ? 7'd0 : pac_y_reg + 7'd1;
      DIR_LEFT:  nbr_x = (pac_x_reg == 8'd0) ? 8'(MAX_X) : pac_x_reg - 8'd1;
      default:   ;
    endcase
  end

  always_comb begin
    if (state_reg == IDLE) begin
      bus.map_x = pac_x_reg;
      bus.map_y = pac_y_reg;
    end else begin
      bus.map_x = nbr_x;
      bus.map_y = nbr_y;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      pac_x_reg     <= 8'(START_X);
      pac_y_reg     <= 7'(START_Y);
      cur_dir_reg   <= DIR_LEFT;
      req_dir_reg   <= DIR_LEFT;
      moving_reg    <= 1'b0;
      step_done_reg <= 1'b0;
    end else begin
      step_done_reg <= 1'b0;
      // Requests latch in any state so the player can pre-turn before a junction.
      if (bus.dir_valid) begin
        req_dir_reg <= bus.dir_req;
      end
      case (state_reg)
        IDLE: begin
          if (bus.tick) begin
            state_reg <= CHK_REQ;
          end
        end
        CHK_REQ: begin
          if (!bus.map_q) begin
            pac_x_reg     <= nbr_x;
            pac_y_reg     <= nbr_y;
            cur_dir_reg   <= req_dir_reg;
            moving_reg    <= 1'b1;
            step_done_reg <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            state_reg <= CHK_CUR;
          end
        end
        CHK_CUR: begin
          if (!bus.map_q) begin
            pac_x_reg     <= nbr_x;
            pac_y_reg     <= nbr_y;
            moving_reg    <= 1'b1;
            step_done_reg <= 1'b1;
          end else begin
            moving_reg <= 1'b0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pac_x     = pac_x_reg;
  assign bus.pac_y     = pac_y_reg;
  assign bus.pac_dir   = cur_dir_reg;
  assign bus.moving    = moving_reg;
  assign bus.step_done = step_done_reg;
endmodule
